barrett_const_gen_32b: RTL and testbench
========================================

// Module: barrett_const_gen_32b
// PURPOSE
//  Sequential precompute unit producing the Barrett constant U = floor(2^64 / M) for a 32-bit modulus M.
//  Feeds the iU input of the 32-bit Barrett modular multiplier.
//  Also returns R = 2^64 mod M, which serves as the Montgomery R^2-style seed.
//  Runs once per modulus change (NTT parameter load), so it is area-lean: one bit per cycle, restoring division.
// PARAMETERS
//  DW      32   modulus width; U is 2*DW bits, remainder DW bits (block verified at DW=32 only)
//  CNT_W   7    iteration counter width, ceil(log2(2*DW))+1
// PORTS
//  iClk    in   1     single clock, rising edge
//  iRst    in   1     asynchronous, active-high reset
//  iEn     in   1     global enable; low freezes all state (stall), outputs hold
//  iClr    in   1     synchronous clear; same effect as reset, takes priority over iEn/iStart
//  iStart  in   1     request; sampled only when oBusy=0 and iEn=1
//  iMod    in   32    modulus M, captured on accepted iStart
//  oBusy   out  1     high from accepted iStart until the final iteration completes
//  oDone   out  1     one-cycle pulse: oU/oRem/oErr valid
//  oErr    out  1     M<2 on last request (U undefined/overflow); sticky until next accepted start
//  oU      out  64    floor(2^64/M); held until next accepted start
//  oRem    out  32    2^64 mod M; held until next accepted start
// BEHAVIOUR
//  Reset/iClr: state=IDLE, cnt=0, all outputs and internal regs 0. Async iRst mid-run aborts; no oDone.
//  FSM: IDLE -(iStart & iEn)-> RUN -(cnt==63 & iEn)-> IDLE with oDone pulse. No separate DONE state.
//  Accept (IDLE, iStart, iEn):
//   - mod_q<=iMod; rem<=33'd1 (leading 1 of 2^64); quo<=0; cnt<=0.
//   - oErr<=(iMod<2); oU/oRem cleared to 0.
//   - If M<2: no RUN; oDone pulses next cycle, oU=0, oRem=0, oErr=1, oBusy stays 0.
//  RUN step (each iEn=1 cycle): t=rem<<1 (33b, bit shifted in is 0).
//   - If t>=M: rem<=t-M, quo<={quo[62:0],1}.
//   - Else: rem<=t, quo<={quo[62:0],0}.
//   - cnt<=cnt+1.
//   - rem invariant < M, so 33b is sufficient; quotient bit 64 is always 0 because M>=2.
//  On step cnt==63: oU<=final quo, oRem<=final rem[31:0], oDone<=1 for one cycle, state<=IDLE.
//  Latency: iStart accepted at edge E0 -> oDone high after edge E64 (65 cycles, no stalls).
//   - Each iEn=0 cycle adds one cycle; an iEn=0 cycle also holds oDone (pulse extends, never lost).
//  iStart while oBusy=1: ignored, not queued. iStart in same cycle as oDone: accepted (back-to-back).
//  iMod changes during RUN: no effect (captured copy used).
//  oBusy is registered: high the cycle after acceptance through the cycle of the final step edge.
//  Compare: unsigned 33b vs {1'b0,M}; subtract unsigned; no signed arithmetic anywhere.
// STRUCTURE
//  Shared package/header: DW, U width (2*DW), FSM state encodings (IDLE=1'b0, RUN=1'b1), CNT_W.
//  One sub-module is natural: restoring_div_step (combinational: rem_in[32:0], mod[31:0] -> rem_out, qbit).
//   - Reusable by a later radix-4 (2-steps/cycle) variant.
//  Top holds FSM, counter, capture regs and output regs. Target 120-200 lines total.
// TESTING
//  M=2 -> oU=64'h8000_0000_0000_0000, oRem=0, oErr=0, oDone exactly 65 cycles after start.
//  M=3 -> oU=64'h5555_5555_5555_5555, oRem=1.
//  M=32'hFFFF_FFFF -> oU=64'h0000_0001_0000_0001, oRem=1.
//  M=32'h8000_0000 -> oU=64'h0000_0002_0000_0000, oRem=0.
//  M=1 and M=0 -> oErr=1, oU=0, oRem=0, oBusy never high, oDone pulse after 1 cycle.
//  Control: iStart re-pulsed mid-run with M=5 -> ignored; first result unchanged.
//   - iEn low 10 cycles mid-run -> oDone at 75 cycles.
//   - iRst at cycle 30 -> all outputs 0, no oDone; next start with M=12289 -> oU=floor(2^64/12289) per model.
//  Random: 1000 random M>=2 vs golden model, back-to-back starts on the oDone cycle.

Source files
------------

// File: rtl/barrett_const_gen_32b_pkg.sv
// Shared widths and FSM encoding for the Barrett constant generator.
package barrett_const_gen_32b_pkg;

  localparam int BCG_DW    = 32;
  localparam int BCG_UW    = 2 * BCG_DW;
  localparam int BCG_CNT_W = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/barrett_const_gen_32b_restoring_div_step.sv
// One restoring-division step: shift the partial remainder left by one zero bit,
// subtract the modulus when it fits, and emit the quotient bit.
module barrett_const_gen_32b_restoring_div_step
  import barrett_const_gen_32b_pkg::*;
#(
  parameter int DW = BCG_DW
) (
  input  logic [DW:0]   rem_i,
  input  logic [DW-1:0] mod_i,
  output logic [DW:0]   rem_o,
  output logic          qbit_o
);

  logic [DW:0] shifted;
  logic [DW:0] modExt;

  assign shifted = rem_i << 1;
  assign modExt  = {1'b0, mod_i};

  always_comb begin
    qbit_o = 1'b0;
    rem_o  = shifted;
    if (shifted >= modExt) begin
      qbit_o = 1'b1;
      rem_o  = shifted - modExt;
    end
  end

endmodule

// File: rtl/barrett_const_gen_32b.sv
// Bit-serial Barrett constant generator: U = floor(2^64 / M) and R = 2^64 mod M,
// one quotient bit per enabled cycle.
module barrett_const_gen_32b
  import barrett_const_gen_32b_pkg::*;
#(
  parameter int DW    = BCG_DW,
  parameter int CNT_W = BCG_CNT_W
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iEn,
  input  logic            iClr,
  input  logic            iStart,
  input  logic [DW-1:0]   iMod,
  output logic            oBusy,
  output logic            oDone,
  output logic            oErr,
  output logic [2*DW-1:0] oU,
  output logic [DW-1:0]   oRem
);

  localparam int UW = 2 * DW;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(UW - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   mod_q, mod_d;
  logic [DW:0]     rem_q, rem_d;
  logic [UW-1:0]   quo_q, quo_d;
  logic [UW-1:0]   u_q, u_d;
  logic [DW-1:0]   remOut_q, remOut_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  logic [DW:0]     stepRem;
  logic            stepQbit;
  logic [UW-1:0]   quoNext;

  barrett_const_gen_32b_restoring_div_step #(.DW(DW)) uStep (
    .rem_i  (rem_q),
    .mod_i  (mod_q),
    .rem_o  (stepRem),
    .qbit_o (stepQbit)
  );

  assign quoNext = {quo_q[UW-2:0], stepQbit};

  // Dividend 2^64 enters as the seed remainder 1 followed by 64 shifted-in zeros.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mod_d    = mod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    u_d      = u_q;
    remOut_d = remOut_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          mod_d    = iMod;
          rem_d    = (DW + 1)'(1);
          quo_d    = '0;
          cnt_d    = '0;
          u_d      = '0;
          remOut_d = '0;
          err_d    = (iMod < DW'(2));
          if (iMod < DW'(2)) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = stepRem;
        quo_d = quoNext;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          u_d      = quoNext;
          remOut_d = stepRem[DW-1:0];
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A low iEn freezes everything, including a pending oDone pulse.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mod_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      u_q      <= '0;
      remOut_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (iClr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mod_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      u_q      <= '0;
      remOut_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (iEn) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mod_q    <= mod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      u_q      <= u_d;
      remOut_q <= remOut_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign oBusy = (state_q == RUN);
  assign oDone = done_q;
  assign oErr  = err_q;
  assign oU    = u_q;
  assign oRem  = remOut_q;

endmodule

// File: tb/tb_barrett_const_gen_32b.sv
// Self-checking bench for barrett_const_gen_32b against a wide-arithmetic reference model.
module tb_barrett_const_gen_32b;

  logic        iClk;
  logic        iRst;
  logic        iEn;
  logic        iClr;
  logic        iStart;
  logic [31:0] iMod;
  logic        oBusy;
  logic        oDone;
  logic        oErr;
  logic [63:0] oU;
  logic [31:0] oRem;

  int checks;
  int failures;

  barrett_const_gen_32b dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iEn    (iEn),
    .iClr   (iClr),
    .iStart (iStart),
    .iMod   (iMod),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oErr   (oErr),
    .oU     (oU),
    .oRem   (oRem)
  );

  // 10-time-unit clock; inputs are driven and outputs sampled on the falling edge.
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reference: 2^64 held in 65 bits, divided with ordinary arithmetic.
  function automatic logic [63:0] modelU(input logic [31:0] m);
    logic [64:0] num;
    logic [64:0] q;
    num = 65'd1 << 64;
    q   = num / {33'd0, m};
    return q[63:0];
  endfunction

  function automatic logic [31:0] modelRem(input logic [31:0] m);
    logic [64:0] num;
    logic [64:0] r;
    num = 65'd1 << 64;
    r   = num % {33'd0, m};
    return r[31:0];
  endfunction

  // Start one request and wait for oDone. Latency counts clock edges from the
  // accepting edge up to and including the edge that raises oDone.
  task automatic runOne(input logic [31:0] m, input int stallAt, input int stallLen,
                        input int pulseAt, input logic [31:0] pulseMod,
                        output int lat, output logic sawBusy, output logic timedOut);
    int cyc;
    @(negedge iClk);
    iStart = 1'b1;
    iMod   = m;
    iEn    = 1'b1;
    @(negedge iClk);
    iStart   = 1'b0;
    iMod     = $urandom;
    cyc      = 0;
    sawBusy  = 1'b0;
    timedOut = 1'b0;
    while (oDone !== 1'b1 && !timedOut) begin
      if (oBusy === 1'b1) sawBusy = 1'b1;
      iEn    = !(cyc >= stallAt && cyc < stallAt + stallLen);
      iStart = (cyc == pulseAt);
      if (cyc == pulseAt) iMod = pulseMod;
      @(negedge iClk);
      cyc++;
      if (cyc > 300) timedOut = 1'b1;
    end
    iEn    = 1'b1;
    iStart = 1'b0;
    lat    = cyc + 1;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iEn = 1'b0; iClr = 1'b0; iStart = 1'b0; iMod = '0;
    repeat (3) @(negedge iClk);
    checks++;
    if ({oBusy, oDone, oErr, oU, oRem} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b err=%b u=%h rem=%h want all zero",
               oBusy, oDone, oErr, oU, oRem);
    end
    iRst = 1'b0;
    iEn  = 1'b1;
    @(negedge iClk);
    checks++;
    if ({oBusy, oDone} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got busy=%b done=%b want 0 0", oBusy, oDone);
    end
  endtask

  typedef struct {
    logic [31:0] m;
    logic [63:0] u;
    logic [31:0] r;
  } corner_t;

  task automatic test_corners();
    corner_t tbl[4];
    int lat;
    logic sawBusy, timedOut;
    tbl[0] = '{32'd2,          64'h8000_0000_0000_0000, 32'd0};
    tbl[1] = '{32'd3,          64'h5555_5555_5555_5555, 32'd1};
    tbl[2] = '{32'hFFFF_FFFF,  64'h0000_0001_0000_0001, 32'd1};
    tbl[3] = '{32'h8000_0000,  64'h0000_0002_0000_0000, 32'd0};
    foreach (tbl[i]) begin
      runOne(tbl[i].m, 1000, 0, -1, '0, lat, sawBusy, timedOut);
      checks++;
      if (timedOut || lat != 65) begin
        failures++;
        $display("[TB] FAIL corner_latency m=%h got %0d want 65", tbl[i].m, lat);
      end
      checks++;
      if (oU !== tbl[i].u || oRem !== tbl[i].r || oErr !== 1'b0) begin
        failures++;
        $display("[TB] FAIL corner_result m=%h got u=%h rem=%h err=%b want u=%h rem=%h err=0",
                 tbl[i].m, oU, oRem, oErr, tbl[i].u, tbl[i].r);
      end
      checks++;
      if (!sawBusy) begin
        failures++;
        $display("[TB] FAIL corner_busy m=%h got busy never high want high during run", tbl[i].m);
      end
      @(negedge iClk);
      checks++;
      if (oDone !== 1'b0 || oU !== tbl[i].u) begin
        failures++;
        $display("[TB] FAIL corner_pulse m=%h got done=%b u=%h want done=0 u=%h",
                 tbl[i].m, oDone, oU, tbl[i].u);
      end
    end
  endtask

  task automatic test_err();
    logic [31:0] ms[2];
    int lat;
    logic sawBusy, timedOut;
    ms[0] = 32'd1;
    ms[1] = 32'd0;
    foreach (ms[i]) begin
      runOne(ms[i], 1000, 0, -1, '0, lat, sawBusy, timedOut);
      checks++;
      if (timedOut || lat != 1 || oBusy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL err_latency m=%0d got lat=%0d busy=%b want lat=1 busy=0",
                 ms[i], lat, oBusy);
      end
      checks++;
      if (oErr !== 1'b1 || oU !== '0 || oRem !== '0) begin
        failures++;
        $display("[TB] FAIL err_result m=%0d got err=%b u=%h rem=%h want err=1 u=0 rem=0",
                 ms[i], oErr, oU, oRem);
      end
      @(negedge iClk);
      checks++;
      if (oDone !== 1'b0 || oErr !== 1'b1) begin
        failures++;
        $display("[TB] FAIL err_sticky m=%0d got done=%b err=%b want done=0 err=1",
                 ms[i], oDone, oErr);
      end
    end
  endtask

  task automatic test_restart_ignored();
    int lat;
    logic sawBusy, timedOut;
    runOne(32'd7, 1000, 0, 20, 32'd5, lat, sawBusy, timedOut);
    checks++;
    if (timedOut || lat != 65 || oU !== modelU(32'd7) || oRem !== modelRem(32'd7)) begin
      failures++;
      $display("[TB] FAIL restart_ignored got lat=%0d u=%h rem=%h want lat=65 u=%h rem=%h",
               lat, oU, oRem, modelU(32'd7), modelRem(32'd7));
    end
  endtask

  task automatic test_stall();
    int lat;
    logic sawBusy, timedOut;
    logic [31:0] m;
    m = $urandom | 32'h0001_0000;
    runOne(m, 20, 10, -1, '0, lat, sawBusy, timedOut);
    checks++;
    if (timedOut || lat != 75) begin
      failures++;
      $display("[TB] FAIL stall_latency got %0d want 75", lat);
    end
    checks++;
    if (oU !== modelU(m) || oRem !== modelRem(m)) begin
      failures++;
      $display("[TB] FAIL stall_result m=%h got u=%h rem=%h want u=%h rem=%h",
               m, oU, oRem, modelU(m), modelRem(m));
    end
    iEn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge iClk);
      checks++;
      if (oDone !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_done_hold k=%0d got done=%b want 1", k, oDone);
      end
    end
    iEn = 1'b1;
    @(negedge iClk);
    checks++;
    if (oDone !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_done_release got done=%b want 0", oDone);
    end
  endtask

  task automatic test_abort();
    int lat;
    logic sawBusy, timedOut;
    logic sawDone;
    @(negedge iClk);
    iStart = 1'b1; iMod = 32'd1000;
    @(negedge iClk);
    iStart = 1'b0;
    repeat (29) @(negedge iClk);
    iRst = 1'b1;
    #1;
    checks++;
    if ({oBusy, oDone, oErr, oU, oRem} !== '0) begin
      failures++;
      $display("[TB] FAIL abort_async got busy=%b done=%b err=%b u=%h rem=%h want all zero",
               oBusy, oDone, oErr, oU, oRem);
    end
    @(negedge iClk);
    iRst = 1'b0;
    sawDone = 1'b0;
    repeat (80) begin
      @(negedge iClk);
      if (oDone === 1'b1 || oBusy === 1'b1) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) begin
      failures++;
      $display("[TB] FAIL abort_no_done got activity after reset want none");
    end
    runOne(32'd12289, 1000, 0, -1, '0, lat, sawBusy, timedOut);
    checks++;
    if (timedOut || oU !== modelU(32'd12289) || oRem !== modelRem(32'd12289)) begin
      failures++;
      $display("[TB] FAIL abort_rerun got u=%h rem=%h want u=%h rem=%h",
               oU, oRem, modelU(32'd12289), modelRem(32'd12289));
    end
  endtask

  task automatic test_clear();
    logic sawDone;
    @(negedge iClk);
    iStart = 1'b1; iMod = 32'd9;
    @(negedge iClk);
    iStart = 1'b0;
    repeat (10) @(negedge iClk);
    iEn  = 1'b0;
    iClr = 1'b1;
    @(negedge iClk);
    iClr = 1'b0;
    iEn  = 1'b1;
    checks++;
    if ({oBusy, oDone, oErr, oU, oRem} !== '0) begin
      failures++;
      $display("[TB] FAIL clear_outputs got busy=%b done=%b err=%b u=%h rem=%h want all zero",
               oBusy, oDone, oErr, oU, oRem);
    end
    sawDone = 1'b0;
    repeat (80) begin
      @(negedge iClk);
      if (oDone === 1'b1) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) begin
      failures++;
      $display("[TB] FAIL clear_no_done got done pulse after clear want none");
    end
  endtask

  function automatic logic [31:0] randMod();
    logic [31:0] m;
    case ($urandom_range(0, 3))
      0:       m = $urandom_range(2, 300);
      1:       m = $urandom >> $urandom_range(0, 31);
      default: m = $urandom;
    endcase
    if (m < 32'd2) m = 32'd2;
    return m;
  endfunction

  task automatic test_back_to_back();
    logic [31:0] m;
    int cyc;
    logic timedOut;
    m = randMod();
    @(negedge iClk);
    iEn = 1'b1; iStart = 1'b1; iMod = m;
    @(negedge iClk);
    iStart = 1'b0;
    iMod   = $urandom;
    for (int n = 0; n < 1000; n++) begin
      cyc = 0;
      timedOut = 1'b0;
      while (oDone !== 1'b1 && !timedOut) begin
        @(negedge iClk);
        cyc++;
        if (cyc > 200) timedOut = 1'b1;
      end
      checks++;
      if (timedOut || cyc + 1 != 65) begin
        failures++;
        $display("[TB] FAIL b2b_latency n=%0d m=%h got %0d want 65", n, m, cyc + 1);
        if (timedOut) break;
      end
      checks++;
      if (oU !== modelU(m) || oRem !== modelRem(m) || oErr !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b_result n=%0d m=%h got u=%h rem=%h err=%b want u=%h rem=%h err=0",
                 n, m, oU, oRem, oErr, modelU(m), modelRem(m));
      end
      if (n < 999) begin
        m = randMod();
        iStart = 1'b1;
        iMod   = m;
        @(negedge iClk);
        iStart = 1'b0;
        iMod   = $urandom;
        checks++;
        if (oDone !== 1'b0 || oBusy !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b_accept n=%0d got done=%b busy=%b want done=0 busy=1",
                   n, oDone, oBusy);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_corners();
    test_err();
    test_restart_ignored();
    test_stall();
    test_abort();
    test_clear();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
